// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq -- sequential 8-bit binary to 3-digit BCD converter
//              (shift-and-add-3, also called double dabble).
//
// A conversion takes eight SHIFT cycles after the accepting edge. The next
// request can be accepted in the cycle where done is high, which gives one
// conversion every nine cycles.
//
// Handshake: a request is taken when start=1 on a rising edge while the FSM
// is in IDLE (busy=0). start is ignored while busy=1 and at any edge where
// sys_rst_n=0. Requests are not queued. done is a one-cycle pulse. bcd_out
// holds its value from one done pulse until the next.
//
// Ports
//   sys_clk    in   1   clock; all state updates on the rising edge
//   sys_rst_n  in   1   synchronous active-low reset
//   start      in   1   conversion request, sampled only in IDLE
//   data_in    in   8   unsigned binary operand, captured on the accepting edge
//   busy       out  1   high exactly while the FSM is in SHIFT
//   done       out  1   registered one-cycle completion pulse
//   bcd_out    out  12  registered result {hundreds, tens, ones}
// -----------------------------------------------------------------------------
module bin2bcd_seq (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd_out
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state, state_nx;
  // [19:8] BCD field (three nibbles), [7:0] binary field still to be shifted in
  logic [19:0] sr, sr_nx, sr_adj;
  logic [2:0]  cnt, cnt_nx;
  logic        done_nx;
  logic [11:0] bcd_nx;

  // Add 3 to every BCD nibble that is 5 or more. Each nibble is adjusted on
  // its own 4 bits, so no carry moves into the next nibble. After the shift
  // this keeps every digit within 0..9.
  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < 3; k++) begin
      if (sr[8 + 4*k +: 4] >= 4'd5)
        sr_adj[8 + 4*k +: 4] = sr[8 + 4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    bcd_nx   = bcd_out;
    case (state)
      IDLE: begin
        if (start) begin
          sr_nx    = {12'd0, data_in};
          cnt_nx   = 3'd0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        sr_nx  = {sr_adj[18:0], 1'b0};
        cnt_nx = cnt + 3'd1;
        // cnt==7 marks the eighth and last shift.
        if (cnt == 3'd7) begin
          bcd_nx   = sr_nx[19:8];
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      sr      <= 20'd0;
      cnt     <= 3'd0;
      done    <= 1'b0;
      bcd_out <= 12'h000;
    end else begin
      state   <= state_nx;
      sr      <= sr_nx;
      cnt     <= cnt_nx;
      done    <= done_nx;
      bcd_out <= bcd_nx;
    end
  end

  // The state register drives busy directly, so busy is registered and is
  // high exactly while the FSM is in SHIFT.
  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq -- self-checking bench for bin2bcd_seq.
// Expected values come from directed vectors and from a decimal-digit model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bin2bcd_seq;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic [7:0]  data_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int          n_checks;
  int          n_errors;
  logic [11:0] exp_q[$];
  logic [11:0] last_bcd;

  bin2bcd_seq dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out)
  );

  // ---------------- clock ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] dec_digits(input int v);
    dec_digits = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Advance one edge and settle 1 ns after it.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Start is raised before the accepting edge (edge N) and dropped after it.
  // data_in is then scrambled to show that only the captured operand matters.
  // Edges N+1..N+7 keep busy high and bcd_out stable. Edge N+8 brings done
  // and the result. The task returns right after edge N+8, so the next call
  // requests in the done cycle (back-to-back).
  task automatic run_conv(input logic [7:0] v, input logic [11:0] exp);
    data_in = v;
    start   = 1'b1;
    tick();
    exp_q.push_back(exp);
    start   = 1'b0;
    data_in = 8'($urandom_range(0, 255));
    check("busy_accept", {11'd0, busy}, 12'd1);
    check("done_accept", {11'd0, done}, 12'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) begin
        check("busy_shift", {11'd0, busy}, 12'd1);
        check("done_shift", {11'd0, done}, 12'd0);
        check("bcd_hold",   bcd_out, last_bcd);
      end else begin
        check("done_pulse", {11'd0, done}, 12'd1);
        check("busy_end",   {11'd0, busy}, 12'd0);
        check("bcd_result", bcd_out, exp_q.pop_front());
        last_bcd = exp;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    last_bcd  = 12'h000;
    sys_rst_n = 1'b0;
    start     = 1'b1;   // must be ignored while in reset
    data_in   = 8'd77;

    // Reset state
    repeat (3) tick();
    check("rst_busy", {11'd0, busy}, 12'd0);
    check("rst_done", {11'd0, done}, 12'd0);
    check("rst_bcd",  bcd_out, 12'h000);

    // The first edge out of reset with start=1 is accepted.
    sys_rst_n = 1'b1;
    run_conv(8'd255, 12'h255);

    // Directed sequence, back-to-back
    run_conv(8'd0,   12'h000);
    run_conv(8'd9,   12'h009);
    run_conv(8'd99,  12'h099);
    run_conv(8'd100, 12'h100);
    tick();
    check("done_low_after", {11'd0, done}, 12'd0);
    check("idle_busy",      {11'd0, busy}, 12'd0);

    // Exhaustive sweep against the decimal-digit model
    for (int v = 0; v < 256; v++) run_conv(8'(v), dec_digits(v));

    // start held for 20 cycles: accepted at c=0,9,18; done at c=8,17,26
    tick();
    data_in = 8'd37;
    start   = 1'b1;
    for (int c = 0; c < 27; c++) begin
      tick();
      if (c == 19) start = 1'b0;
      check("hold_done", {11'd0, done}, {11'd0, (c % 9 == 8)});
      check("hold_busy", {11'd0, busy}, {11'd0, (c % 9 != 8)});
      if (c % 9 == 8) check("hold_bcd", bcd_out, 12'h037);
    end
    last_bcd = 12'h037;
    tick();
    check("hold_quiet", {11'd0, done}, 12'd0);

    // A new start and operand at edge N+4 are ignored.
    data_in = 8'd200;
    start   = 1'b1;
    tick();                      // edge N
    start   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) begin data_in = 8'd17; start = 1'b1; end
      tick();
      if (i == 4) start = 1'b0;
      if (i < 8) begin
        check("ign_busy", {11'd0, busy}, 12'd1);
        check("ign_done", {11'd0, done}, 12'd0);
        check("ign_hold", bcd_out, last_bcd);
      end else begin
        check("ign_done_pulse", {11'd0, done}, 12'd1);
        check("ign_bcd",        bcd_out, 12'h200);
      end
    end
    last_bcd = 12'h200;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ign_no_restart", {11'd0, (busy | done)}, 12'd0);
    end

    // Reset at edge N+5 aborts the conversion.
    data_in = 8'd128;
    start   = 1'b1;
    tick();                      // edge N
    start   = 1'b0;
    repeat (4) tick();           // edges N+1..N+4
    sys_rst_n = 1'b0;
    tick();                      // edge N+5
    check("abort_busy", {11'd0, busy}, 12'd0);
    check("abort_done", {11'd0, done}, 12'd0);
    check("abort_bcd",  bcd_out, 12'h000);
    sys_rst_n = 1'b1;
    last_bcd  = 12'h000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort_no_done", {11'd0, done}, 12'd0);
      check("abort_bcd_hold", bcd_out, 12'h000);
    end
    run_conv(8'd5,   12'h005);
    run_conv(8'd128, 12'h128);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have no parameters; binary width is fixed at 8 bits and BCD width at 12 bits.
REQ-002 sys_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 sys_rst_n  input  1  synchronous, active-low reset, sampled on the sys_clk rising edge.
REQ-004 start  input  1  conversion request; one-cycle pulse or level, sampled only in IDLE.
REQ-005 data_in  input  8  unsigned binary operand, captured on the accepting edge.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  registered one-cycle completion pulse.
REQ-008 bcd_out  output  12  registered result: [11:8] hundreds, [7:4] tens, [3:0] ones.

Function
REQ-009 The FSM SHALL have two states: IDLE and SHIFT.
REQ-010 Internal 20-bit shift register: [19:8] BCD field (three nibbles), [7:0] binary field; 3-bit step counter.
REQ-011 IDLE, start=1 at edge N: load shift register with {12'd0, data_in}, clear counter, busy<=1, go to SHIFT.
REQ-012 IDLE, start=0: hold all state; busy=0.
REQ-013 Each SHIFT edge: every BCD nibble whose value is >=5 SHALL receive +3 (4-bit, no carry into the next nibble), then the whole 20-bit word SHALL shift left by 1 with 0 into bit 0; counter increments.
REQ-014 SHIFT SHALL execute exactly 8 steps, at edges N+1..N+8.
REQ-015 At edge N+8: bcd_out <= post-shift bits [19:8], done<=1, busy<=0, go to IDLE.
REQ-016 done SHALL be high for exactly the one cycle following edge N+8 and low at all other times.
REQ-017 Latency SHALL be 8 cycles from the accepting edge to done high; throughput SHALL be one conversion per 9 cycles.
REQ-018 bcd_out SHALL hold its value from one done pulse until the next; it SHALL NOT change during SHIFT.
REQ-019 start asserted while busy=1 SHALL be ignored, neither queued nor restarting the conversion.
REQ-020 start asserted in the cycle done=1 (state IDLE) SHALL be accepted as a new request (back-to-back).
REQ-021 data_in changes after the accepting edge SHALL NOT affect the result.
REQ-022 Every BCD nibble of the result SHALL be within 0..9 for every input 0..255; the hundreds nibble SHALL be within 0..2.
REQ-023 busy SHALL be 1 exactly when the state is SHIFT.

Reset
REQ-024 sys_rst_n=0 at an edge SHALL force state IDLE, shift register 0, counter 0, busy=0, done=0, bcd_out=12'h000.
REQ-025 Reset during SHIFT SHALL abort the conversion with no done pulse; bcd_out SHALL read 0.
REQ-026 start SHALL be ignored at any edge where sys_rst_n=0; the first edge with sys_rst_n=1 and start=1 SHALL be accepted.

Verification
REQ-027 data_in=8'd255, start pulse -> busy high for 8 cycles, done high 1 cycle after edge N+8, bcd_out=12'h255.
REQ-028 data_in=0, 9, 99, 100 in sequence -> bcd_out=12'h000, 12'h009, 12'h099, 12'h100, one done pulse each.
REQ-029 Exhaustive sweep 0..255 -> bcd_out equals the decimal digits of the input; no nibble >9.
REQ-030 start=1 held for 20 cycles with data_in=8'd37 -> conversion accepted in consecutive IDLE cycles (every 9 cycles), done pulses every 9 cycles, bcd_out=12'h037; no restart while busy.
REQ-031 data_in=8'd200, start; at edge N+4 change data_in to 8'd17 and pulse start -> result 12'h200, one done pulse, the second start ignored.
REQ-032 data_in=8'd128, start; sys_rst_n=0 at edge N+5 -> busy=0, done never asserted, bcd_out=12'h000; a new start after reset release converts normally.
